tone_decoder: RTL



---
 rtl/tone_decoder.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/tone_decoder.sv
// tone_decoder: measures the half-period of a square-wave tone line and
// decodes it into the one-hot note/pitch encoding used by the buzzer.
// Optional build macro TONE_DEC_HOLD_EN: when defined, note/pitch keep the
// last decoded values across silence and only valid drops.
`timescale 1ns/1ps
module tone_decoder #(
    parameter int STABLE_CNT = 2,
    parameter int TIMEOUT    = 1000000,
    parameter int CW         = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tone_in,
    output logic [6:0] note,
    output logic [2:0] pitch,
    output logic       valid,
    output logic       changed
);

    localparam logic [CW-1:0] TMO = CW'(TIMEOUT);
    localparam logic [2:0]    STB = 3'(STABLE_CNT);

    // Target half-periods, low octave do..si, then middle, then high.
    localparam int unsigned HALF [21] = '{
        381681, 340137, 303031, 286369, 255103, 227274, 202430,
        191113, 170069, 151516, 142858, 127552, 113637, 101216,
         95557,  85035,  75758,  71430,  63777,  56819,  50608
    };

    // Period counter increment that sticks at the timeout value.
    function automatic logic [CW-1:0] cnt_sat(input logic [CW-1:0] c);
        return (c >= TMO) ? TMO : c + 1'b1;
    endfunction

    // Streak increment that sticks at the largest representable streak.
    function automatic logic [2:0] streak_sat(input logic [2:0] s);
        return (s == 3'd7) ? s : s + 3'd1;
    endfunction

    // Table lookup: returns {pitch, note} one-hot, or zero when unmatched.
    function automatic logic [9:0] match_tbl(input logic [CW-1:0] m);
        logic [9:0]  r;
        int unsigned mv;
        int unsigned t;
        int unsigned tol;
        r  = '0;
        mv = 32'(m);
        if (m != TMO) begin
            for (int i = 0; i < 21; i++) begin
                t   = HALF[i];
                tol = t >> 6;
                if (mv >= t - tol && mv <= t + tol)
                    r = {3'(1 << (i / 7)), 7'(1 << (i % 7))};
            end
        end
        return r;
    endfunction

    logic          sync_p0, sync_p1, tone_d;
    logic          tone_edge;
    logic [CW-1:0] cnt;
    logic          ref_seen;
    logic          silence;
    logic          vld_p1;
    logic [9:0]    res_p1;
    logic [2:0]    streak;
    logic [9:0]    last_res;

    logic [6:0]    note_n;
    logic [2:0]    pitch_n;
    logic          valid_n;
    logic [2:0]    streak_n;
    logic [9:0]    last_n;
    logic          changed_n;

    assign tone_edge = sync_p1 ^ tone_d;
    assign silence   = (cnt == TMO) && !tone_edge;

    // Stage p0: synchronize the asynchronous tone line and keep a delayed copy for edge detect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            tone_d  <= 1'b0;
        end else begin
            sync_p0 <= tone_in;
            sync_p1 <= sync_p0;
            tone_d  <= sync_p1;
        end
    end

    // Stage p0: count cycles between edges; an edge restarts the count at 1 so cnt equals the spacing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            ref_seen <= 1'b0;
        end else if (tone_edge) begin
            cnt      <= CW'(1);
            ref_seen <= 1'b1;
        end else begin
            cnt      <= cnt_sat(cnt);
            if (silence)
                ref_seen <= 1'b0;
        end
    end

    // Stage p1: register the table match of each non-reference measurement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            res_p1 <= '0;
        end else begin
            vld_p1 <= tone_edge && ref_seen;
            if (tone_edge)
                res_p1 <= match_tbl(cnt);
        end
    end

    // Stage p2 next-state: streak tracking, stable update, silence handling and change detect.
    always_comb begin
        note_n   = note;
        pitch_n  = pitch;
        valid_n  = valid;
        streak_n = streak;
        last_n   = last_res;
        if (silence) begin
            valid_n  = 1'b0;
            streak_n = 3'd0;
`ifndef TONE_DEC_HOLD_EN
            note_n   = '0;
            pitch_n  = '0;
`endif
        end else if (vld_p1) begin
            if (streak != 3'd0 && res_p1 == last_res) begin
                streak_n = streak_sat(streak);
            end else begin
                streak_n = 3'd1;
                last_n   = res_p1;
            end
            if (streak_n >= STB) begin
                pitch_n = res_p1[9:7];
                note_n  = res_p1[6:0];
                valid_n = (res_p1 != 10'd0);
            end
        end
        changed_n = ({note_n, pitch_n, valid_n} != {note, pitch, valid});
    end

    // Stage p2: output and streak registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            note     <= '0;
            pitch    <= '0;
            valid    <= 1'b0;
            changed  <= 1'b0;
            streak   <= '0;
            last_res <= '0;
        end else begin
            note     <= note_n;
            pitch    <= pitch_n;
            valid    <= valid_n;
            changed  <= changed_n;
            streak   <= streak_n;
            last_res <= last_n;
        end
    end

endmodule
